mips_program_loader: RTL and testbench
======================================

# mips_program_loader

Host-side loader sitting between the UART receiver and `top_mips`. It assembles a byte stream into 32-bit instruction words, drives the CPU preload port until the halt sentinel 0xFFFFFFFF is written, then releases CPU reset and runs the core in continuous or single-step mode under byte commands. It replaces the stimulus process used in simulation, so the same program image can be loaded on the board.

## Interface
Parameters:
- `LEN`, 32, instruction word and address width
- `NB_BYTE`, 8, UART byte width
- `RAM_DEPTH_PROGRAM`, 32, number of program memory words

Ports:
- `i_clk`  in  1  system clock (the CPU's `o_clk` domain)
- `i_rst`  in  1  reset, synchronous, active-low
- `i_rx_data`  in  NB_BYTE  received byte
- `i_rx_valid`  in  1  one-cycle strobe qualifying `i_rx_data`
- `o_preload_flag`  out  1  one-cycle write strobe to program memory
- `o_preload_address`  out  LEN  word index being written
- `o_preload_instruction`  out  LEN  word being written
- `o_cpu_rst`  out  1  CPU reset, active-low (0 = CPU held in reset)
- `o_step_mode_flag`  out  1  1 = CPU clocked by `o_step`
- `o_step`  out  1  one-cycle step pulse
- `o_overflow`  out  1  sticky: memory filled without a sentinel

## Operation
- States: LOAD, MODE, RUN_CONT, RUN_STEP.
- LOAD: `o_cpu_rst`=0. A 2-bit byte counter collects bytes MSB first. On the 4th byte the word is complete: assert `o_preload_flag` for one cycle with the current address and the word, then increment the address.
  - If the word equals 0xFFFFFFFF, it is written and the block moves to MODE.
  - Else, if the address was RAM_DEPTH_PROGRAM-1, the word is written, `o_overflow` is set, and the block moves to MODE.
- MODE: `o_cpu_rst` stays 0. Byte 0x43 ('C') selects RUN_CONT. Byte 0x53 ('S') selects RUN_STEP. Byte 0x52 ('R') selects LOAD. All other bytes are ignored.
- RUN_CONT: `o_cpu_rst`=1, `o_step_mode_flag`=0.
- RUN_STEP: `o_cpu_rst`=1, `o_step_mode_flag`=1. Byte 0x4E ('N') produces a one-cycle `o_step` pulse.
- In RUN_STEP, 'C' moves to RUN_CONT without resetting the CPU. In RUN_CONT, 'S' moves to RUN_STEP without resetting the CPU.
- 'R' in either RUN state returns to LOAD. On entry to LOAD:
  - `o_cpu_rst` = 0 in the next cycle;
  - address, byte counter and `o_overflow` are cleared.
- All other bytes in the RUN states are ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `o_preload_flag`=0, `o_preload_address`=0, `o_preload_instruction`=0
  - `o_cpu_rst`=0, `o_step_mode_flag`=0, `o_step`=0, `o_overflow`=0
  - state = LOAD, byte counter = 0
- Write latency: `o_preload_flag` rises in the cycle after the `i_rx_valid` carrying the 4th byte. Address and instruction are valid in that same cycle and hold until the next write.
- Back-to-back bytes (`i_rx_valid` every cycle) are accepted with no loss. Writes can then occur every 4 cycles.
- The state changes to MODE in the same cycle the sentinel write strobe is high.
- Mode changes: `o_cpu_rst` and `o_step_mode_flag` change in the cycle after the command byte's strobe. `o_step` pulses in the cycle after the 'N' strobe.
- Reset mid-word discards the partial bytes. Reset during a RUN state returns to LOAD with the CPU held in reset.
- `o_step` is never asserted while `o_cpu_rst`=0.

## Structure
- Shared package `mips_debug_pkg` holds:
  - command byte constants (CMD_CONT 0x43, CMD_STEP 0x53, CMD_NEXT 0x4E, CMD_RELOAD 0x52);
  - HALT_WORD 32'hFFFFFFFF;
  - loader state encoding.
- One sub-module, `byte_word_assembler` (byte counter plus shift register, emits `word_valid`/`word`), with a clear input driven on entry to LOAD. The FSM lives in the top.

## Test plan
- Stream 0x20,0x01,0x00,0x05 then FF,FF,FF,FF → writes addr 0 = 0x20010005 and addr 1 = 0xFFFFFFFF. Each `o_preload_flag` lasts 1 cycle, 1 cycle after the 4th byte. State = MODE with `o_cpu_rst`=0.
- Then 'S', then three 'N' → `o_cpu_rst`=1, `o_step_mode_flag`=1, exactly three 1-cycle `o_step` pulses. Follow with 'C' → `o_step_mode_flag`=0 while `o_cpu_rst` stays 1.
- 32 non-sentinel words (0x00000001..0x00000020) → addresses 0..31 written, `o_overflow`=1 after the last write, state = MODE. A following 'C' still runs the CPU.
- Bytes sent every cycle for 3 words plus the sentinel → 4 writes spaced 4 cycles apart, no byte lost.
- Two bytes of a word, then `i_rst`=0 for 1 cycle, then a full word 0xAABBCCDD → single write of 0xAABBCCDD at addr 0.
- In RUN_CONT send 'R', then reload one word plus the sentinel → `o_cpu_rst`=0 in the next cycle, the address restarts at 0, `o_overflow` is cleared. Stray 'N' in MODE gives no `o_step`.

Source files
------------

// File: rtl/mips_debug_pkg.sv
// Shared constants and loader state encoding for the MIPS debug/loader path.
package mips_debug_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_CONT   = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP   = 8'h53;  // 'S'
  localparam logic [7:0] CMD_NEXT   = 8'h4E;  // 'N'
  localparam logic [7:0] CMD_RELOAD = 8'h52;  // 'R'

  // Writing this word ends the program image
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_MODE     = 2'd1,
    ST_RUN_CONT = 2'd2,
    ST_RUN_STEP = 2'd3
  } loader_state_e;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a byte stream, MSB first, into LEN-bit words. word_valid_o is
// combinational and high while the last byte of a word is on byte_i.
module byte_word_assembler #(
  parameter int LEN     = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               clear_i,
  input  logic [NB_BYTE-1:0] byte_i,
  input  logic               valid_i,
  output logic               word_valid_o,
  output logic [LEN-1:0]     word_o
);

  // Only the bytes before the last one need storage; the last is taken live.
  logic [1:0]             cnt_q, cnt_d;
  logic [LEN-NB_BYTE-1:0] shift_q, shift_d;

  // Byte counter and shift register update
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[LEN-2*NB_BYTE-1:0], byte_i};
    end
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign word_valid_o = valid_i && !clear_i && (cnt_q == 2'd3);
  assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/mips_program_loader.sv
// Host-side loader: assembles UART bytes into instruction words, preloads
// program memory until the halt word, then runs the CPU under byte commands.
//
//   state       | meaning
//   ST_LOAD     | CPU in reset, collecting words into program memory
//   ST_MODE     | image loaded, CPU in reset, waiting for C/S/R
//   ST_RUN_CONT | CPU running freely
//   ST_RUN_STEP | CPU clocked by o_step, one pulse per 'N'
module mips_program_loader
  import mips_debug_pkg::*;
#(
  parameter int LEN               = 32,
  parameter int NB_BYTE           = 8,
  parameter int RAM_DEPTH_PROGRAM = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_preload_flag,
  output logic [LEN-1:0]     o_preload_address,
  output logic [LEN-1:0]     o_preload_instruction,
  output logic               o_cpu_rst,
  output logic               o_step_mode_flag,
  output logic               o_step,
  output logic               o_overflow
);

  localparam logic [LEN-1:0] LAST_ADDR = LEN'(RAM_DEPTH_PROGRAM - 1);

  loader_state_e  state_q, state_d;
  logic [LEN-1:0] next_addr_q, next_addr_d;
  logic [LEN-1:0] addr_q, addr_d;
  logic [LEN-1:0] instr_q, instr_d;
  logic           flag_q, flag_d;
  logic           cpu_rst_q, cpu_rst_d;
  logic           step_mode_q, step_mode_d;
  logic           step_q, step_d;
  logic           ovf_q, ovf_d;

  logic           asm_clear;
  logic           asm_valid;
  logic           word_valid;
  logic [LEN-1:0] word;
  logic           reload_req;

  // Bytes only feed the assembler while loading; commands never do.
  assign asm_valid = i_rx_valid && (state_q == ST_LOAD);

  byte_word_assembler #(
    .LEN     (LEN),
    .NB_BYTE (NB_BYTE)
  ) u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .clear_i      (asm_clear),
    .byte_i       (i_rx_data),
    .valid_i      (asm_valid),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    flag_d      = 1'b0;
    step_d      = 1'b0;
    ovf_d       = ovf_q;
    asm_clear   = 1'b0;
    reload_req  = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (word_valid) begin
          flag_d      = 1'b1;
          addr_d      = next_addr_q;
          instr_d     = word;
          next_addr_d = next_addr_q + LEN'(1);
          if (word == LEN'(HALT_WORD)) begin
            state_d = ST_MODE;
          end else if (next_addr_q == LAST_ADDR) begin
            ovf_d   = 1'b1;
            state_d = ST_MODE;
          end
        end
      end
      ST_MODE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_CONT:   state_d    = ST_RUN_CONT;
            CMD_STEP:   state_d    = ST_RUN_STEP;
            CMD_RELOAD: reload_req = 1'b1;
            default:    ;
          endcase
        end
      end
      ST_RUN_CONT: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_STEP:   state_d    = ST_RUN_STEP;
            CMD_RELOAD: reload_req = 1'b1;
            default:    ;
          endcase
        end
      end
      ST_RUN_STEP: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_CONT:   state_d    = ST_RUN_CONT;
            CMD_NEXT:   step_d     = 1'b1;
            CMD_RELOAD: reload_req = 1'b1;
            default:    ;
          endcase
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Entering LOAD restarts the image from address 0
    if (reload_req) begin
      state_d     = ST_LOAD;
      next_addr_d = '0;
      addr_d      = '0;
      ovf_d       = 1'b0;
      asm_clear   = 1'b1;
    end

    // CPU control follows the state being entered, so it changes one cycle
    // after the command strobe. o_step only arises inside RUN_STEP, where
    // o_cpu_rst is already 1.
    cpu_rst_d   = (state_d == ST_RUN_CONT) || (state_d == ST_RUN_STEP);
    step_mode_d = (state_d == ST_RUN_STEP);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= ST_LOAD;
      next_addr_q <= '0;
      addr_q      <= '0;
      instr_q     <= '0;
      flag_q      <= 1'b0;
      cpu_rst_q   <= 1'b0;
      step_mode_q <= 1'b0;
      step_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      flag_q      <= flag_d;
      cpu_rst_q   <= cpu_rst_d;
      step_mode_q <= step_mode_d;
      step_q      <= step_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_preload_flag        = flag_q;
  assign o_preload_address     = addr_q;
  assign o_preload_instruction = instr_q;
  assign o_cpu_rst             = cpu_rst_q;
  assign o_step_mode_flag      = step_mode_q;
  assign o_step                = step_q;
  assign o_overflow            = ovf_q;

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed bench for mips_program_loader: load, overflow, run/step control,
// back-to-back bytes and reset recovery.
module tb_mips_program_loader;
  import mips_debug_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        preload_flag;
  logic [31:0] preload_address;
  logic [31:0] preload_instruction;
  logic        cpu_rst;
  logic        step_mode_flag;
  logic        step;
  logic        overflow;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int step_cnt = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  mips_program_loader dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_rx_data             (rx_data),
    .i_rx_valid            (rx_valid),
    .o_preload_flag        (preload_flag),
    .o_preload_address     (preload_address),
    .o_preload_instruction (preload_instruction),
    .o_cpu_rst             (cpu_rst),
    .o_step_mode_flag      (step_mode_flag),
    .o_step                (step),
    .o_overflow            (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  // Write log and step monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (preload_flag) begin
      wr_addr.push_back(preload_address);
      wr_data.push_back(preload_instruction);
      wr_cyc.push_back(cyc);
    end
    if (step) begin
      step_cnt++;
      check("step_while_cpu_run", 32'(cpu_rst), 32'd1);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive(b);
    idle(1);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic burst_word(input logic [31:0] w);
    drive(w[31:24]);
    drive(w[23:16]);
    drive(w[15:8]);
    drive(w[7:0]);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    idle(3);
    check("rst_flag",     32'(preload_flag), 32'd0);
    check("rst_addr",     preload_address, 32'd0);
    check("rst_instr",    preload_instruction, 32'd0);
    check("rst_cpu_rst",  32'(cpu_rst), 32'd0);
    check("rst_stepmode", 32'(step_mode_flag), 32'd0);
    check("rst_step",     32'(step), 32'd0);
    check("rst_ovf",      32'(overflow), 32'd0);
    check("rst_state",    32'(dut.state_q), 32'(ST_LOAD));
    rst = 1'b1;
    idle(2);

    // First word plus sentinel, one byte every other cycle
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h05);
    check("w0_flag",  32'(preload_flag), 32'd1);
    check("w0_addr",  preload_address, 32'd0);
    check("w0_instr", preload_instruction, 32'h2001_0005);
    idle(1);
    check("w0_flag_1cyc", 32'(preload_flag), 32'd0);
    check("w0_addr_hold", preload_address, 32'd0);
    send_word(32'hFFFF_FFFF);
    check("halt_flag",   32'(preload_flag), 32'd1);
    check("halt_addr",   preload_address, 32'd1);
    check("halt_instr",  preload_instruction, 32'hFFFF_FFFF);
    check("halt_state",  32'(dut.state_q), 32'(ST_MODE));
    check("halt_cpurst", 32'(cpu_rst), 32'd0);
    idle(2);
    check("load1_nwr", 32'(wr_addr.size()), 32'd2);

    // Stray 'N' in MODE gives nothing
    send_byte(CMD_NEXT);
    idle(2);
    check("mode_n_nostep", 32'(step_cnt), 32'd0);
    check("mode_n_state",  32'(dut.state_q), 32'(ST_MODE));

    // Single-step mode
    send_byte(CMD_STEP);
    check("s_cpurst",   32'(cpu_rst), 32'd1);
    check("s_stepmode", 32'(step_mode_flag), 32'd1);
    send_byte(CMD_NEXT);
    check("n1_step", 32'(step), 32'd1);
    idle(1);
    check("n1_step_1cyc", 32'(step), 32'd0);
    send_byte(CMD_NEXT);
    idle(1);
    send_byte(CMD_NEXT);
    idle(2);
    check("n_count", 32'(step_cnt), 32'd3);
    send_byte(CMD_CONT);
    check("c_stepmode", 32'(step_mode_flag), 32'd0);
    check("c_cpurst",   32'(cpu_rst), 32'd1);

    // Reload from RUN_CONT, then overflow the memory
    send_byte(CMD_RELOAD);
    check("r_cpurst", 32'(cpu_rst), 32'd0);
    check("r_state",  32'(dut.state_q), 32'(ST_LOAD));
    clear_log();
    for (int i = 1; i <= 32; i++) send_word(32'(i));
    idle(2);
    check("ovf_nwr", 32'(wr_addr.size()), 32'd32);
    for (int i = 0; i < 32; i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("ovf_addr%0d", i), wr_addr[i], 32'(i));
        check($sformatf("ovf_data%0d", i), wr_data[i], 32'(i + 1));
      end
    end
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_state", 32'(dut.state_q), 32'(ST_MODE));
    send_byte(CMD_CONT);
    check("ovf_c_cpurst",   32'(cpu_rst), 32'd1);
    check("ovf_c_stepmode", 32'(step_mode_flag), 32'd0);

    // 'R' in RUN_CONT clears overflow and restarts at address 0
    send_byte(CMD_RELOAD);
    check("r2_cpurst", 32'(cpu_rst), 32'd0);
    check("r2_ovf",    32'(overflow), 32'd0);
    clear_log();
    send_word(32'h1234_5678);
    send_word(32'hFFFF_FFFF);
    idle(2);
    check("r2_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      check("r2_addr0", wr_addr[0], 32'd0);
      check("r2_data0", wr_data[0], 32'h1234_5678);
      check("r2_addr1", wr_addr[1], 32'd1);
      check("r2_data1", wr_data[1], 32'hFFFF_FFFF);
    end
    check("r2_state", 32'(dut.state_q), 32'(ST_MODE));

    // Back-to-back bytes: 3 words plus sentinel
    send_byte(CMD_RELOAD);
    clear_log();
    burst_word(32'hA0A1_A2A3);
    burst_word(32'hB0B1_B2B3);
    burst_word(32'hC0C1_C2C3);
    burst_word(32'hFFFF_FFFF);
    idle(3);
    check("bb_nwr", 32'(wr_addr.size()), 32'd4);
    if (wr_addr.size() >= 4) begin
      check("bb_data0", wr_data[0], 32'hA0A1_A2A3);
      check("bb_data1", wr_data[1], 32'hB0B1_B2B3);
      check("bb_data2", wr_data[2], 32'hC0C1_C2C3);
      check("bb_data3", wr_data[3], 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++)
        check($sformatf("bb_addr%0d", i), wr_addr[i], 32'(i));
      for (int i = 1; i < 4; i++)
        check($sformatf("bb_gap%0d", i), 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd4);
    end

    // Reset while running puts the CPU back in reset in LOAD
    send_byte(CMD_CONT);
    check("rr_cpurst_run", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rr_cpurst", 32'(cpu_rst), 32'd0);
    check("rr_state",  32'(dut.state_q), 32'(ST_LOAD));

    // Reset mid-word discards partial bytes
    clear_log();
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send_word(32'hAABB_CCDD);
    idle(3);
    check("mw_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() >= 1) begin
      check("mw_addr", wr_addr[0], 32'd0);
      check("mw_data", wr_data[0], 32'hAABB_CCDD);
    end
    check("mw_state", 32'(dut.state_q), 32'(ST_LOAD));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
